// File: rtl/osd_rect_overlay.sv
// -----------------------------------------------------------------------------
// osd_rect_overlay
//
// Draws one programmable rectangle (solid fill or outline) onto an Avalon-ST
// RGB video stream, one pixel per beat. Register values come from the OSD
// register bank conduit and are shadowed on every video-packet header beat, so
// CPU writes during a frame only take effect from the next frame.
//
// Optional feature macro: OSD_ALPHA_BLEND_EN
//   defined   : shadowed reg0 bit2 = 1 makes replaced pixels the per-channel
//               average of the incoming pixel and the colour.
//   undefined : reg0 bit2 is ignored; hit pixels take the colour exactly.
//
// Register map (reg i = conduit_signal[32*i+31:32*i]):
//   reg0 : bit0 enable, bit1 mode (0 fill, 1 border), bit2 blend
//   reg1 : x_start[15:0], x_end[31:16]
//   reg2 : y_start[15:0], y_end[31:16]
//   reg3 : colour[DATA_WIDTH-1:0]
//   reg4 : border thickness[3:0]
//   reg5 : line width in pixels[15:0] (0 means 65536)
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   conduit_signal        : flattened register vector from the register bank
//   din_*                 : Avalon-ST sink (data, valid, sop, eop, ready)
//   dout_*                : Avalon-ST source (data, valid, sop, eop, ready)
//
// Handshake: a beat moves on valid && ready. The block has a single output
// register; din_ready = dout_ready || !dout_valid, so a beat is accepted
// whenever the output register is empty or being drained this cycle, and the
// dout_* signals hold steady while dout_valid && !dout_ready.
//
// FSM state is held in state_q (type state_t) for hierarchical observation.
// -----------------------------------------------------------------------------
module osd_rect_overlay #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [(1<<(ADDR_WIDTH+5))-1:0] conduit_signal,
  input  logic [DATA_WIDTH-1:0]          din_data,
  input  logic                           din_valid,
  input  logic                           din_startofpacket,
  input  logic                           din_endofpacket,
  output logic                           din_ready,
  output logic [DATA_WIDTH-1:0]          dout_data,
  output logic                           dout_valid,
  output logic                           dout_startofpacket,
  output logic                           dout_endofpacket,
  input  logic                           dout_ready
);

  localparam int CH_W = DATA_WIDTH / 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VIDEO = 2'd1,
    ST_PASS  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic in_fire;
  assign din_ready = dout_ready || !dout_valid;
  assign in_fire   = din_valid && din_ready;

  // Only some conduit bits are meaningful; the rest are deliberately ignored.
  logic unused_conduit;
  assign unused_conduit = ^conduit_signal;

  // ---------------------------------------------------------------------------
  // Shadow registers, loaded on a video header beat
  // ---------------------------------------------------------------------------
  logic                  shadow_load;
  logic                  sh_en, sh_mode;
  logic [15:0]           sh_xs, sh_xe, sh_ys, sh_ye, sh_w;
  logic [3:0]            sh_t;
  logic [DATA_WIDTH-1:0] sh_colour;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_en     <= 1'b0;
      sh_mode   <= 1'b0;
      sh_xs     <= '0;
      sh_xe     <= '0;
      sh_ys     <= '0;
      sh_ye     <= '0;
      sh_w      <= '0;
      sh_t      <= '0;
      sh_colour <= '0;
    end else if (shadow_load) begin
      sh_en     <= conduit_signal[0];
      sh_mode   <= conduit_signal[1];
      sh_xs     <= conduit_signal[32*1 +: 16];
      sh_xe     <= conduit_signal[32*1+16 +: 16];
      sh_ys     <= conduit_signal[32*2 +: 16];
      sh_ye     <= conduit_signal[32*2+16 +: 16];
      sh_colour <= conduit_signal[32*3 +: DATA_WIDTH];
      sh_t      <= conduit_signal[32*4 +: 4];
      sh_w      <= conduit_signal[32*5 +: 16];
    end
  end

`ifdef OSD_ALPHA_BLEND_EN
  logic sh_blend;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_blend <= 1'b0;
    end else if (shadow_load) begin
      sh_blend <= conduit_signal[2];
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state / control decode
  // ---------------------------------------------------------------------------
  logic cnt_clear, cnt_adv, pix_beat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shadow_load = 1'b0;
    cnt_clear   = 1'b0;
    cnt_adv     = 1'b0;
    pix_beat    = 1'b0;
    if (in_fire) begin
      if (din_startofpacket) begin
        // A header always restarts parsing, even if the previous packet
        // never delivered its EOP.
        if (din_endofpacket) begin
          state_d = ST_IDLE;
        end else if (din_data[3:0] == 4'd0) begin
          state_d     = ST_VIDEO;
          shadow_load = 1'b1;
          cnt_clear   = 1'b1;
        end else begin
          state_d = ST_PASS;
        end
      end else begin
        if (state_q == ST_VIDEO) begin
          pix_beat = 1'b1;
          cnt_adv  = 1'b1;
        end
        // EOP beat is handled under the current state's rule above first.
        if (din_endofpacket) begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel position counters
  // ---------------------------------------------------------------------------
  logic [15:0] x_q, y_q;
  logic [16:0] w_last;
  logic        x_wrap;

  // Width 0 stands for 65536 pixels, so the last column index is 0xFFFF.
  assign w_last = (sh_w == 16'd0) ? 17'h0FFFF : ({1'b0, sh_w} - 17'd1);
  assign x_wrap = ({1'b0, x_q} == w_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (cnt_clear) begin
      x_q <= '0;
      y_q <= '0;
    end else if (cnt_adv) begin
      if (x_wrap) begin
        x_q <= '0;
        if (y_q != 16'hFFFF) begin
          y_q <= y_q + 16'd1;
        end
      end else begin
        x_q <= x_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hit test. Everything is widened to 17 bits and the "end - t" side is
  // rewritten as "pos + t > end" so no compare can wrap around.
  // ---------------------------------------------------------------------------
  logic [16:0] x17, y17, xs17, xe17, ys17, ye17, t17;
  logic        in_rect, on_border, hit;

  assign x17  = {1'b0, x_q};
  assign y17  = {1'b0, y_q};
  assign xs17 = {1'b0, sh_xs};
  assign xe17 = {1'b0, sh_xe};
  assign ys17 = {1'b0, sh_ys};
  assign ye17 = {1'b0, sh_ye};
  assign t17  = {13'd0, sh_t};

  // An inverted range (end < start) can never satisfy both bounds.
  assign in_rect   = (x17 >= xs17) && (x17 <= xe17) &&
                     (y17 >= ys17) && (y17 <= ye17);
  assign on_border = (x17 < xs17 + t17) || (x17 + t17 > xe17) ||
                     (y17 < ys17 + t17) || (y17 + t17 > ye17);
  assign hit       = pix_beat && sh_en && in_rect && (!sh_mode || on_border);

  // ---------------------------------------------------------------------------
  // Replacement pixel
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] repl_pix;

`ifdef OSD_ALPHA_BLEND_EN
  logic [DATA_WIDTH-1:0] blend_pix;
  logic [CH_W:0]         ch_sum;

  always_comb begin
    blend_pix = '0;
    ch_sum    = '0;
    for (int c = 0; c < 3; c++) begin
      ch_sum = {1'b0, din_data[c*CH_W +: CH_W]} + {1'b0, sh_colour[c*CH_W +: CH_W]};
      blend_pix[c*CH_W +: CH_W] = ch_sum[CH_W:1];
    end
  end

  assign repl_pix = sh_blend ? blend_pix : sh_colour;
`else
  assign repl_pix = sh_colour;
`endif

  // ---------------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_valid         <= 1'b0;
      dout_data          <= '0;
      dout_startofpacket <= 1'b0;
      dout_endofpacket   <= 1'b0;
    end else if (din_ready) begin
      dout_valid <= din_valid;
      if (din_valid) begin
        dout_data          <= hit ? repl_pix : din_data;
        dout_startofpacket <= din_startofpacket;
        dout_endofpacket   <= din_endofpacket;
      end
    end
  end

endmodule

// File: tb/tb_osd_rect_overlay.sv
// -----------------------------------------------------------------------------
// tb_osd_rect_overlay
//
// Directed sequence of frames with random pixel data and random register
// configurations. Expected beats are produced by a behavioural model that
// works from packet beat index and plain integer geometry, and are checked in
// order by a scoreboard monitor; stall holding and 1-cycle latency are checked
// alongside.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_osd_rect_overlay;

  localparam int AW = 3;
  localparam int DW = 24;
  localparam int RW = 1 << (AW + 5);

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT signals
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] conduit_signal = '0;
  logic [DW-1:0] din_data = '0;
  logic          din_valid = 1'b0;
  logic          din_startofpacket = 1'b0;
  logic          din_endofpacket = 1'b0;
  logic          din_ready;
  logic [DW-1:0] dout_data;
  logic          dout_valid;
  logic          dout_startofpacket;
  logic          dout_endofpacket;
  logic          dout_ready = 1'b1;

  int            checks = 0;
  int            errors = 0;
  logic [DW+1:0] exp_q[$];
  logic [31:0]   regs[8];
  logic [31:0]   snap[8];
  bit            stall_en = 1'b0;
  bit            lat_chk_en = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    dout_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  osd_rect_overlay #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .conduit_signal     (conduit_signal),
    .din_data           (din_data),
    .din_valid          (din_valid),
    .din_startofpacket  (din_startofpacket),
    .din_endofpacket    (din_endofpacket),
    .din_ready          (din_ready),
    .dout_data          (dout_data),
    .dout_valid         (dout_valid),
    .dout_startofpacket (dout_startofpacket),
    .dout_endofpacket   (dout_endofpacket),
    .dout_ready         (dout_ready)
  );

  // ---------------------------------------------------------------------------
  // Reference model: expected pixel from frame position and frame-start regs
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] exp_pixel(input int x, input int y, input logic [DW-1:0] p);
    int xs, xe, ys, ye, t;
    bit in_r, edge_hit;
    logic [DW-1:0] c, r;
    xs = int'(snap[1][15:0]);
    xe = int'(snap[1][31:16]);
    ys = int'(snap[2][15:0]);
    ye = int'(snap[2][31:16]);
    t  = int'(snap[4][3:0]);
    c  = snap[3][DW-1:0];
    if (snap[0][0] == 1'b0) return p;
    in_r     = (x >= xs) && (x <= xe) && (y >= ys) && (y <= ye);
    edge_hit = (x < xs + t) || (x > xe - t) || (y < ys + t) || (y > ye - t);
    if (!in_r) return p;
    if (snap[0][1] == 1'b1 && !edge_hit) return p;
`ifdef OSD_ALPHA_BLEND_EN
    if (snap[0][2] == 1'b1) begin
      r = '0;
      for (int ch = 0; ch < 3; ch++) begin
        r[ch*8 +: 8] = 8'((int'(p[ch*8 +: 8]) + int'(c[ch*8 +: 8])) / 2);
      end
      return r;
    end
`endif
    r = c;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic set_reg(input int i, input logic [31:0] v);
    regs[i] = v;
    conduit_signal[32*i +: 32] = v;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic sop, input logic eop,
                           input logic [DW-1:0] expd);
    int n;
    n = 0;
    din_data          = d;
    din_startofpacket = sop;
    din_endofpacket   = eop;
    din_valid         = 1'b1;
    exp_q.push_back({sop, eop, expd});
    @(negedge clk);
    while (din_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 1000) else begin
      errors++;
      $error("FAIL accept_timeout waited=%0d required<1000", n);
    end
    @(posedge clk);
    #1;
    din_valid         = 1'b0;
    din_startofpacket = 1'b0;
    din_endofpacket   = 1'b0;
  endtask

  // Video packet: header (type 0) plus npix pixels; optional reg1 rewrite
  // right after pixel index mid_idx.
  task automatic send_frame(input int npix, input bit rnd, input bit with_eop,
                            input int mid_idx, input logic [31:0] mid_v);
    logic [DW-1:0] h, p;
    int wd, x, y;
    snap = regs;
    wd = (snap[5][15:0] == 16'd0) ? 65536 : int'(snap[5][15:0]);
    h = DW'($urandom);
    h[3:0] = 4'd0;
    send_beat(h, 1'b1, 1'b0, h);
    for (int i = 0; i < npix; i++) begin
      p = rnd ? DW'($urandom) : '0;
      x = i % wd;
      y = i / wd;
      if (y > 65535) y = 65535;
      send_beat(p, 1'b0, with_eop && (i == npix - 1), exp_pixel(x, y, p));
      if (i == mid_idx) set_reg(1, mid_v);
    end
  endtask

  // Non-video packet: header of type 0xF plus nbody data beats.
  task automatic send_ctrl(input int nbody);
    logic [DW-1:0] h, p;
    h = DW'($urandom);
    h[3:0] = 4'hF;
    send_beat(h, 1'b1, 1'b0, h);
    for (int i = 0; i < nbody; i++) begin
      p = DW'($urandom);
      send_beat(p, 1'b0, i == nbody - 1, p);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    din_valid = 1'b0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain pending=%0d required=0", exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic monitor();
    logic [DW+1:0] obs, e, held;
    bit hold_pend, fire_prev;
    hold_pend = 1'b0;
    fire_prev = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      obs = {dout_startofpacket, dout_endofpacket, dout_data};
      if (rst_n === 1'b1) begin
        if (hold_pend) begin
          checks++;
          assert (dout_valid === 1'b1 && obs === held) else begin
            errors++;
            $error("FAIL stall_hold got=%h valid=%b required=%h valid=1", obs, dout_valid, held);
          end
        end
        if (lat_chk_en) begin
          checks++;
          assert (dout_valid === fire_prev) else begin
            errors++;
            $error("FAIL latency dout_valid=%b required=%b", dout_valid, fire_prev);
          end
        end
        if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL extra_beat got=%h required=none", obs);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (obs === e) else begin
              errors++;
              $error("FAIL beat got=%h required=%h", obs, e);
            end
          end
        end
      end
      hold_pend = (rst_n === 1'b1) && (dout_valid === 1'b1) && (dout_ready === 1'b0);
      held      = obs;
      fire_prev = (rst_n === 1'b1) && (din_valid === 1'b1) && (din_ready === 1'b1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] p, h;
    foreach (regs[i]) regs[i] = '0;
    snap = regs;
    fork
      monitor();
    join_none

    // Reset held for two clocks
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    assert (dout_valid === 1'b0) else begin
      errors++; $error("FAIL reset_valid got=%b required=0", dout_valid);
    end
    checks++;
    assert (dout_data === {DW{1'b0}}) else begin
      errors++; $error("FAIL reset_data got=%h required=0", dout_data);
    end
    checks++;
    assert (din_ready === 1'b1) else begin
      errors++; $error("FAIL reset_ready got=%b required=1", din_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lat_chk_en = 1'b1;

    // Overlay disabled: 4x2 frame passes untouched
    set_reg(5, 32'd4);
    set_reg(1, {16'd3, 16'd0});
    set_reg(2, {16'd1, 16'd0});
    set_reg(3, 32'h00123456);
    send_frame(8, 1'b1, 1'b1, -1, 32'd0);
    idle(2);

    // Fill: 8x3 black frame, rect x 2..4, y 1
    set_reg(0, 32'd1);
    set_reg(1, {16'd4, 16'd2});
    set_reg(2, {16'd1, 16'd1});
    set_reg(3, 32'h00FF0000);
    set_reg(5, 32'd8);
    send_frame(24, 1'b0, 1'b1, -1, 32'd0);

    // Border: rect 1..6 x 0..3 on an 8x4 frame with t=1, t=0, t=15
    set_reg(0, 32'd3);
    set_reg(1, {16'd6, 16'd1});
    set_reg(2, {16'd3, 16'd0});
    set_reg(4, 32'd1);
    send_frame(32, 1'b0, 1'b1, -1, 32'd0);
    set_reg(4, 32'd0);
    send_frame(32, 1'b0, 1'b1, -1, 32'd0);
    set_reg(4, 32'd15);
    send_frame(32, 1'b1, 1'b1, -1, 32'd0);

    // Inverted x range never hits
    set_reg(0, 32'd1);
    set_reg(1, {16'd1, 16'd6});
    send_frame(32, 1'b1, 1'b1, -1, 32'd0);

    // Control packet is untouched; reg1 written mid-frame applies next frame
    set_reg(1, {16'd7, 16'd0});
    set_reg(2, {16'hFFFF, 16'd0});
    send_ctrl(2);
    send_frame(16, 1'b1, 1'b1, 4, {16'd3, 16'd2});
    send_frame(16, 1'b1, 1'b1, -1, 32'd0);

    // Missing EOP: a new header restarts counters and reshadows
    set_reg(1, {16'd5, 16'd1});
    send_frame(5, 1'b1, 1'b0, -1, 32'd0);
    set_reg(1, {16'd2, 16'd0});
    send_frame(16, 1'b1, 1'b1, -1, 32'd0);

    // SOP and EOP on one beat: the following beat has no header and passes
    h = DW'($urandom);
    h[3:0] = 4'd0;
    send_beat(h, 1'b1, 1'b1, h);
    p = DW'($urandom);
    send_beat(p, 1'b0, 1'b1, p);
    idle(1);

    // Width 0 is a 65536-wide line: all pixels stay on row 0
    set_reg(5, 32'd0);
    set_reg(1, {16'd20, 16'd3});
    set_reg(2, {16'd0, 16'd0});
    send_frame(24, 1'b1, 1'b1, -1, 32'd0);

    // Random backpressure over a 16x4 frame
    drain();
    lat_chk_en = 1'b0;
    stall_en = 1'b1;
    set_reg(0, 32'($urandom_range(0, 1)) | 32'd1);
    set_reg(1, {16'($urandom_range(4, 15)), 16'($urandom_range(0, 4))});
    set_reg(2, {16'($urandom_range(1, 3)), 16'($urandom_range(0, 1))});
    set_reg(3, $urandom);
    set_reg(4, 32'd2);
    set_reg(5, 32'd16);
    send_frame(64, 1'b1, 1'b1, -1, 32'd0);
    drain();
    stall_en = 1'b0;
    idle(3);
    lat_chk_en = 1'b1;

    // Random configurations
    for (int k = 0; k < 6; k++) begin
      set_reg(0, 32'($urandom_range(0, 3)));
      set_reg(1, {16'($urandom_range(0, 9)), 16'($urandom_range(0, 9))});
      set_reg(2, {16'($urandom_range(0, 5)), 16'($urandom_range(0, 5))});
      set_reg(3, $urandom);
      set_reg(4, 32'($urandom_range(0, 5)));
      set_reg(5, 32'($urandom_range(0, 10)));
      send_frame(30, 1'b1, 1'b1, -1, 32'd0);
      idle(k % 2);
    end

`ifdef OSD_ALPHA_BLEND_EN
    // Blend: (0x204060 + 0x6080A0) / 2 per channel
    set_reg(0, 32'd5);
    set_reg(1, 32'd0);
    set_reg(2, 32'd0);
    set_reg(3, 32'h006080A0);
    set_reg(5, 32'd1);
    snap = regs;
    h = '0;
    send_beat(h, 1'b1, 1'b0, h);
    send_beat(24'h204060, 1'b0, 1'b1, 24'h406080);
    idle(1);
`endif

    // Reset mid-packet: following headerless beats pass unmodified
    set_reg(0, 32'd1);
    set_reg(1, {16'hFFFF, 16'd0});
    set_reg(2, {16'hFFFF, 16'd0});
    set_reg(3, 32'h00ABCDEF);
    set_reg(5, 32'd4);
    send_frame(3, 1'b1, 1'b0, -1, 32'd0);
    drain();
    lat_chk_en = 1'b0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    lat_chk_en = 1'b1;
    p = DW'($urandom);
    send_beat(p, 1'b0, 1'b0, p);
    h = DW'($urandom);
    send_beat(h, 1'b0, 1'b1, h);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/osd_rect_overlay.md
Name: osd_rect_overlay

Overview:
- Downstream consumer of the OSD register bank's conduit outputs.
- Takes the 8x32-bit register vector and draws one programmable solid or outlined rectangle onto an Avalon-ST video stream, 1 pixel per beat, RGB888.
- Sits inline in the video pipe between frame source and output stage.
- Registers are shadowed at frame start so CPU writes never tear a frame.

Parameters:
- ADDR_WIDTH, 3, register-bank address width; conduit width is 1<<(ADDR_WIDTH+5); must be >=3 (regs 0-5 used).
- DATA_WIDTH, 24, pixel width; 3 channels of DATA_WIDTH/3 bits, R in MSBs.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- conduit_signal  in  1<<(ADDR_WIDTH+5)  register vector; reg i = bits [32i+31:32i]
- din_data  in  DATA_WIDTH  input pixel/header beat
- din_valid  in  1  input beat valid
- din_startofpacket  in  1  first beat of packet
- din_endofpacket  in  1  last beat of packet
- din_ready  out  1  block accepts beat
- dout_data  out  DATA_WIDTH  output beat
- dout_valid  out  1  output beat valid
- dout_startofpacket  out  1  SOP passthrough
- dout_endofpacket  out  1  EOP passthrough
- dout_ready  in  1  sink accepts beat

Behaviour:
- Register map:
  - reg0 bit0 enable; bit1 mode (0 fill, 1 border); bit2 blend (feature only).
  - reg1 x_start[15:0], x_end[31:16].
  - reg2 y_start[15:0], y_end[31:16].
  - reg3 colour[DATA_WIDTH-1:0].
  - reg4 border thickness[3:0].
  - reg5 line width in pixels[15:0].
  - reg6/7 ignored.
- Handshake:
  - Beat transfers on valid&&ready.
  - din_ready = dout_ready || !dout_valid.
  - One output register stage; latency 1 cycle.
  - dout_* hold stable while dout_valid && !dout_ready.
- Reset: all state and outputs clear; dout_* = 0, shadow regs = 0 (overlay off). din_ready follows its combinational equation, so it is 1 during reset.
- FSM, transitions on accepted input beats only:
  - IDLE: wait for SOP.
  - SOP beat: header; din_data[3:0] is packet type; beat passes unmodified.
    - Type 0 -> VIDEO; shadow all registers on this beat; x=0, y=0.
    - Any other type -> PASS.
  - VIDEO: each beat is a pixel at (x,y).
    - x increments; when x == width-1, x=0 and y++ (y saturates at 0xFFFF).
    - Width 0 is treated as 65536.
  - PASS: beats untouched.
  - EOP in any state -> IDLE; the EOP beat is processed under the current state's rule first.
  - SOP while not IDLE (missing EOP): treat as new header; restart counters and reshadow.
  - SOP and EOP on the same beat: header only, back to IDLE.
- Hit test, bounds inclusive:
  - inside = x_start<=x<=x_end && y_start<=y<=y_end.
  - x_end<x_start or y_end<y_start: no pixel hits.
- Fill mode: replace when inside.
- Border mode: replace when inside && (x<x_start+t || x>x_end-t || y<y_start+t || y>y_end-t), with t = thickness.
  - All compares done at 17 bits; no wrap.
  - t=0: draws nothing.
  - t larger than half the rectangle: whole rectangle filled.
- enable=0 in shadow: pure passthrough, 1-cycle latency.
- Register changes mid-frame: no effect until the next video SOP.
- Reset mid-packet: drops state; next beat without SOP stays in IDLE and passes unmodified.

Optional Feature:
- OSD_ALPHA_BLEND_EN defined: when shadow reg0 bit2=1, replaced pixels become per-channel (pixel+colour)>>1, using a 1-bit-wider adder; latency unchanged.
- Undefined: bit2 ignored; hit pixels take colour exactly.

Test Plan:
- Reset with rst_n=0 for 2 clks -> dout_valid=0, dout_data=0; 4x2 video frame with enable=0 -> all 9 beats out unchanged, 1-cycle latency.
- Fill: width=8, rect x 2..4, y 1..1, colour 0xFF0000, 8x3 frame of 0x000000 -> exactly beats (2..4,1) = 0xFF0000, header unchanged.
- Border: width=8, rect 1..6 x 0..3, t=1, 8x4 frame -> perimeter pixels coloured, (2..5,1..2) untouched; t=0 -> nothing coloured.
- Random dout_ready backpressure (~50%) over a 16x4 frame -> output sequence identical to the no-stall run, no beat lost or duplicated, dout held while stalled.
- Control packet (type 0xF) 3 beats, then write reg1 mid-video-frame -> control beats unmodified; new x range applies only from the following frame.
- OSD_ALPHA_BLEND_EN, bit2=1, pixel 0x204060, colour 0x6080A0 -> 0x406080.
